// File: rtl/udp_tx_arbiter_if.sv
// Bundle of per-requester header/payload streams and the merged stream
// toward the UDP stack; slave is the arbiter view, master the far ends.
interface udp_tx_arbiter_if #(
  parameter int PORT_COUNT = 2,
  parameter int HDR_WIDTH  = 80,
  parameter int DATA_WIDTH = 8
);
  logic [PORT_COUNT-1:0]            s_hdr_valid;
  logic [PORT_COUNT-1:0]            s_hdr_ready;
  logic [PORT_COUNT*HDR_WIDTH-1:0]  s_hdr_data;
  logic [PORT_COUNT*DATA_WIDTH-1:0] s_tdata;
  logic [PORT_COUNT-1:0]            s_tvalid;
  logic [PORT_COUNT-1:0]            s_tready;
  logic [PORT_COUNT-1:0]            s_tlast;
  logic                             m_hdr_valid;
  logic                             m_hdr_ready;
  logic [HDR_WIDTH-1:0]             m_hdr_data;
  logic [DATA_WIDTH-1:0]            m_tdata;
  logic                             m_tvalid;
  logic                             m_tready;
  logic                             m_tlast;

  modport slave (
    input  s_hdr_valid, s_hdr_data, s_tdata,
    input  s_tvalid, s_tlast,
    input  m_hdr_ready, m_tready,
    output s_hdr_ready, s_tready,
    output m_hdr_valid, m_hdr_data,
    output m_tdata, m_tvalid, m_tlast
  );

  modport master (
    output s_hdr_valid, s_hdr_data, s_tdata,
    output s_tvalid, s_tlast,
    output m_hdr_ready, m_tready,
    input  s_hdr_ready, s_tready,
    input  m_hdr_valid, m_hdr_data,
    input  m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/udp_tx_arbiter.sv
// Round-robin packet arbiter: N header+payload requesters onto one UDP tx.
// Ports: clk, reset (sync, high), bus (slave), grant (owner), busy.
module udp_tx_arbiter #(
  parameter int PORT_COUNT = 2,
  parameter int HDR_WIDTH  = 80,
  parameter int DATA_WIDTH = 8,
  localparam int GW = $clog2(PORT_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  udp_tx_arbiter_if.slave   bus,
  output logic [GW-1:0]     grant,
  output logic              busy
);

  localparam int SW = GW + 1;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] pick;
  logic [SW-1:0] sum;
  logic          hdr_hs;
  logic          end_hs;

  // Walk downward so the candidate nearest rr_ptr is assigned last.
  always_comb begin
    pick = rr_ptr;
    sum  = '0;
    for (int k = PORT_COUNT - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + SW'(k);
      if (sum >= SW'(PORT_COUNT))
        sum = sum - SW'(PORT_COUNT);
      if (bus.s_hdr_valid[sum[GW-1:0]])
        pick = sum[GW-1:0];
    end
  end

  always_comb begin
    bus.s_hdr_ready = '0;
    bus.s_tready    = '0;
    bus.m_hdr_valid = 1'b0;
    bus.m_tvalid    = 1'b0;
    bus.m_tlast     = 1'b0;
    bus.m_hdr_data  =
      bus.s_hdr_data[grant*HDR_WIDTH +: HDR_WIDTH];
    bus.m_tdata     =
      bus.s_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
    unique case (state)
      HEADER: begin
        bus.m_hdr_valid        = bus.s_hdr_valid[grant];
        bus.s_hdr_ready[grant] = bus.m_hdr_ready;
      end
      PAYLOAD: begin
        bus.m_tvalid        = bus.s_tvalid[grant];
        bus.m_tlast         = bus.s_tlast[grant];
        bus.s_tready[grant] = bus.m_tready;
      end
      default: ;
    endcase
  end

  assign hdr_hs = bus.m_hdr_valid & bus.m_hdr_ready;
  assign end_hs = bus.m_tvalid & bus.m_tready
                & bus.m_tlast;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
      busy   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.s_hdr_valid) begin
            grant <= pick;
            busy  <= 1'b1;
            state <= HEADER;
          end
        end
        HEADER: begin
          if (hdr_hs)
            state <= PAYLOAD;
        end
        PAYLOAD: begin
          if (end_hs) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= (grant == GW'(PORT_COUNT - 1))
                    ? '0 : grant + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter with an in-order scoreboard.
// Two instances: 2-port (main scenarios) and 4-port (rr from 3).
module tb_udp_tx_arbiter;

  localparam int HW = 80;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:0] grant_a;
  logic [1:0] grant_b;
  logic       busy_a;
  logic       busy_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_end = -10;

  int          exp_hp[$];
  logic [79:0] exp_hd[$];
  int          exp_bp[$];
  logic [7:0]  exp_bd[$];
  logic        exp_bl[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  udp_tx_arbiter_if #(.PORT_COUNT(2), .HDR_WIDTH(HW),
    .DATA_WIDTH(DW)) ifa ();
  udp_tx_arbiter_if #(.PORT_COUNT(4), .HDR_WIDTH(HW),
    .DATA_WIDTH(DW)) ifb ();

  udp_tx_arbiter #(.PORT_COUNT(2), .HDR_WIDTH(HW),
    .DATA_WIDTH(DW)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa),
    .grant(grant_a), .busy(busy_a));

  udp_tx_arbiter #(.PORT_COUNT(4), .HDR_WIDTH(HW),
    .DATA_WIDTH(DW)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb),
    .grant(grant_b), .busy(busy_b));

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] mk_hdr(
    input int p, input logic [15:0] dport,
    input int len);
    return {32'hC0A8_0001, 16'(16'h1000 + p),
            dport, 16'(len)};
  endfunction

  task automatic expect_pkt(input int p,
    input logic [79:0] h, input int n,
    input logic [7:0] base, input int lim);
    exp_hp.push_back(p);
    exp_hd.push_back(h);
    for (int i = 0; i < lim; i++) begin
      exp_bp.push_back(p);
      exp_bd.push_back(base + 8'(i));
      exp_bl.push_back(i == n - 1);
    end
  endtask

  task automatic mon_hdr(input logic [79:0] d,
                         input int g);
    int p;
    logic [79:0] h;
    chk("hdr_q", {127'd0, exp_hd.size() > 0}, 1);
    if (exp_hd.size() > 0) begin
      p = exp_hp.pop_front();
      h = exp_hd.pop_front();
      chk("hdr_data", d, h);
      chk("hdr_grant", g, p);
      chk("idle_gap", {127'd0, cyc - last_end >= 2}, 1);
    end
  endtask

  task automatic mon_beat(input logic [7:0] d,
                          input logic l, input int g);
    chk("beat_q", {127'd0, exp_bd.size() > 0}, 1);
    if (exp_bd.size() > 0) begin
      chk("beat_grant", g, exp_bp.pop_front());
      chk("beat_data", d, exp_bd.pop_front());
      chk("beat_last", l, exp_bl.pop_front());
      if (l) last_end = cyc;
    end
  endtask

  always @(negedge clk) begin
    if (ifa.m_hdr_valid && ifa.m_hdr_ready)
      mon_hdr(ifa.m_hdr_data, int'(grant_a));
    if (ifa.m_tvalid) begin
      chk("a_tready_mirror", ifa.s_tready,
          ifa.m_tready ? (2'b01 << grant_a) : 2'b00);
      if (ifa.m_tready)
        mon_beat(ifa.m_tdata, ifa.m_tlast,
                 int'(grant_a));
    end
    if (busy_a === 1'b0)
      chk("a_idle_quiet", {ifa.s_hdr_ready,
          ifa.s_tready, ifa.m_hdr_valid,
          ifa.m_tvalid}, 0);
    if (ifb.m_hdr_valid && ifb.m_hdr_ready)
      mon_hdr(ifb.m_hdr_data, int'(grant_b));
    if (ifb.m_tvalid && ifb.m_tready)
      mon_beat(ifb.m_tdata, ifb.m_tlast,
               int'(grant_b));
    if (busy_b === 1'b0)
      chk("b_idle_quiet", {ifb.s_hdr_ready,
          ifb.s_tready, ifb.m_hdr_valid,
          ifb.m_tvalid}, 0);
  end

  // Beat 0 is offered alongside the header to check it waits.
  task automatic send_a(input int p,
    input logic [79:0] h, input int n,
    input logic [7:0] base, input int lim);
    int  sent = 0;
    int  budget = 0;
    bit  hdone = 0;
    bit  hs, bs;
    ifa.s_hdr_data[p*HW +: HW] = h;
    ifa.s_hdr_valid[p] = 1'b1;
    ifa.s_tdata[p*DW +: DW] = base;
    ifa.s_tvalid[p] = 1'b1;
    ifa.s_tlast[p] = (n == 1);
    while ((!hdone || sent < lim) && budget < 300) begin
      @(negedge clk);
      hs = ifa.s_hdr_valid[p] && ifa.s_hdr_ready[p];
      bs = ifa.s_tvalid[p] && ifa.s_tready[p];
      @(posedge clk);
      #1;
      if (hs) begin
        hdone = 1;
        ifa.s_hdr_valid[p] = 1'b0;
      end
      if (bs) begin
        sent++;
        if (sent == lim) begin
          ifa.s_tvalid[p] = 1'b0;
          ifa.s_tlast[p] = 1'b0;
        end else begin
          ifa.s_tdata[p*DW +: DW] = base + 8'(sent);
          ifa.s_tlast[p] = (sent == n - 1);
        end
      end
      budget++;
    end
    chk("a_drv_progress", {hdone, 32'(sent)},
        {1'b1, 32'(lim)});
  endtask

  task automatic send_b(input int p,
    input logic [79:0] h, input logic [7:0] d);
    int  budget = 0;
    bit  hdone = 0;
    bit  bdone = 0;
    bit  hs, bs;
    ifb.s_hdr_data[p*HW +: HW] = h;
    ifb.s_hdr_valid[p] = 1'b1;
    ifb.s_tdata[p*DW +: DW] = d;
    ifb.s_tvalid[p] = 1'b1;
    ifb.s_tlast[p] = 1'b1;
    while (!(hdone && bdone) && budget < 300) begin
      @(negedge clk);
      hs = ifb.s_hdr_valid[p] && ifb.s_hdr_ready[p];
      bs = ifb.s_tvalid[p] && ifb.s_tready[p];
      @(posedge clk);
      #1;
      if (hs) begin
        hdone = 1;
        ifb.s_hdr_valid[p] = 1'b0;
      end
      if (bs) begin
        bdone = 1;
        ifb.s_tvalid[p] = 1'b0;
        ifb.s_tlast[p] = 1'b0;
      end
      budget++;
    end
    chk("b_drv_progress", {hdone, bdone}, 2'b11);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [79:0] h0, h1, h2, h3;
    reset = 1'b1;
    ifa.s_hdr_valid = '1;
    ifa.s_tvalid = '1;
    ifa.s_tlast = '1;
    ifa.s_hdr_data = '0;
    ifa.s_tdata = '0;
    ifa.m_hdr_ready = 1'b1;
    ifa.m_tready = 1'b1;
    ifb.s_hdr_valid = '1;
    ifb.s_tvalid = '1;
    ifb.s_tlast = '1;
    ifb.s_hdr_data = '0;
    ifb.s_tdata = '0;
    ifb.m_hdr_ready = 1'b1;
    ifb.m_tready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_readies", {ifa.s_hdr_ready, ifa.s_tready,
        ifb.s_hdr_ready, ifb.s_tready}, 0);
    chk("rst_mvalid", {ifa.m_hdr_valid, ifa.m_tvalid,
        ifa.m_tlast, ifb.m_hdr_valid, ifb.m_tvalid}, 0);
    chk("rst_busy", {busy_a, busy_b}, 0);
    chk("rst_grant", {grant_a, grant_b}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ifa.s_hdr_valid = '0;
    ifa.s_tvalid = '0;
    ifa.s_tlast = '0;
    ifb.s_hdr_valid = '0;
    ifb.s_tvalid = '0;
    ifb.s_tlast = '0;
    repeat (2) @(posedge clk);
    #1;

    h1 = mk_hdr(1, 16'h1234, 4);
    expect_pkt(1, h1, 4, 8'hA0, 4);
    fork
      send_a(1, h1, 4, 8'hA0, 4);
      begin
        @(negedge clk);
        chk("lat_before", ifa.m_hdr_valid, 0);
        @(negedge clk);
        chk("lat_hdr_valid", ifa.m_hdr_valid, 1);
        chk("lat_grant", grant_a, 1);
        chk("lat_busy", busy_a, 1);
        chk("dest_port", ifa.m_hdr_data[31:16],
            16'h1234);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    h0 = mk_hdr(0, 16'h0101, 2);
    h1 = mk_hdr(1, 16'h0202, 2);
    expect_pkt(0, h0, 2, 8'h10, 2);
    expect_pkt(1, h1, 2, 8'h20, 2);
    fork
      send_a(0, h0, 2, 8'h10, 2);
      send_a(1, h1, 2, 8'h20, 2);
    join
    repeat (2) @(posedge clk);
    #1;

    h0 = mk_hdr(0, 16'h0BBB, 3);
    expect_pkt(0, h0, 3, 8'hC0, 3);
    ifa.m_hdr_ready = 1'b0;
    fork
      send_a(0, h0, 3, 8'hC0, 3);
      begin
        repeat (3) @(posedge clk);
        #1;
        ifa.m_hdr_ready = 1'b1;
        for (int i = 0; i < 50 && !ifa.m_tvalid; i++)
          @(negedge clk);
        @(posedge clk);
        #1;
        ifa.m_tready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        ifa.m_tready = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;

    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    h0 = mk_hdr(0, 16'h3000, 2);
    h1 = mk_hdr(1, 16'h3111, 2);
    h2 = mk_hdr(0, 16'h3222, 1);
    expect_pkt(0, h0, 2, 8'h30, 2);
    expect_pkt(1, h1, 2, 8'h40, 2);
    expect_pkt(0, h2, 1, 8'h50, 1);
    fork
      begin
        send_a(0, h0, 2, 8'h30, 2);
        send_a(0, h2, 1, 8'h50, 1);
      end
      send_a(1, h1, 2, 8'h40, 2);
    join
    repeat (2) @(posedge clk);
    #1;

    h1 = mk_hdr(1, 16'h5555, 5);
    expect_pkt(1, h1, 5, 8'hB0, 2);
    send_a(1, h1, 5, 8'hB0, 2);
    ifa.m_tready = 1'b0;
    ifa.s_tdata[DW +: DW] = 8'hB2;
    ifa.s_tvalid[1] = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_busy", busy_a, 0);
    chk("mrst_grant", grant_a, 0);
    chk("mrst_mvalid", {ifa.m_hdr_valid, ifa.m_tvalid,
        ifa.m_tlast}, 0);
    chk("mrst_readies", {ifa.s_hdr_ready,
        ifa.s_tready}, 0);
    ifa.s_tvalid[1] = 1'b0;
    ifa.m_tready = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    h1 = mk_hdr(1, 16'h6666, 2);
    expect_pkt(1, h1, 2, 8'hE0, 2);
    send_a(1, h1, 2, 8'hE0, 2);
    repeat (2) @(posedge clk);
    #1;

    h2 = mk_hdr(2, 16'h7002, 1);
    expect_pkt(2, h2, 1, 8'h72, 1);
    send_b(2, h2, 8'h72);
    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      h2 = mk_hdr(2, 16'(16'h8002 + r), 1);
      h3 = mk_hdr(3, 16'(16'h8003 + r), 1);
      expect_pkt(3, h3, 1, 8'(8'h93 + r), 1);
      expect_pkt(2, h2, 1, 8'(8'h82 + r), 1);
      fork
        send_b(3, h3, 8'(8'h93 + r));
        send_b(2, h2, 8'(8'h82 + r));
      join
      repeat (2) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", exp_hd.size() + exp_bd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_tx_arbiter.md
UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

Interface
REQ-001 SHALL have parameter PORT_COUNT, default 2: number of requesters (2..16).
REQ-002 SHALL have parameter HDR_WIDTH, default 80: packed header {dest_ip[31:0], src_port[15:0], dest_port[15:0], length[15:0]}.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: payload beat width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port s_hdr_valid  in  PORT_COUNT  per-requester header valid.
REQ-007 SHALL have port s_hdr_ready  out  PORT_COUNT  per-requester header ready.
REQ-008 SHALL have port s_hdr_data  in  PORT_COUNT*HDR_WIDTH  headers; requester i at [i*HDR_WIDTH +: HDR_WIDTH].
REQ-009 SHALL have ports s_tdata (in, PORT_COUNT*DATA_WIDTH), s_tvalid (in, PORT_COUNT), s_tready (out, PORT_COUNT) and s_tlast (in, PORT_COUNT), forming the per-requester payload AXIS.
REQ-010 SHALL have ports m_hdr_valid (out, 1), m_hdr_ready (in, 1) and m_hdr_data (out, HDR_WIDTH), forming the header toward the UDP stack.
REQ-011 SHALL have ports m_tdata (out, DATA_WIDTH), m_tvalid (out, 1), m_tready (in, 1) and m_tlast (out, 1), forming the payload toward the UDP stack.
REQ-012 SHALL have port grant  out  $clog2(PORT_COUNT)  index of the current owner; valid while busy=1.
REQ-013 SHALL have port busy  out  1  high in states HEADER and PAYLOAD.

Function
REQ-014 SHALL implement the FSM IDLE -> HEADER -> PAYLOAD -> IDLE, one packet per grant, with no interleaving between requesters.
REQ-015 In IDLE with any s_hdr_valid high, SHALL register grant as the first set bit of s_hdr_valid, searching from rr_ptr upward modulo PORT_COUNT, and SHALL enter HEADER on the next cycle.
REQ-016 SHALL impose a latency of one cycle from s_hdr_valid rising in IDLE to m_hdr_valid high; all s_*_ready SHALL be 0 while in IDLE.
REQ-017 In HEADER: m_hdr_valid = s_hdr_valid[grant]; m_hdr_data = header slice [grant]; s_hdr_ready[grant] = m_hdr_ready; the transfer completes combinationally with no buffering.
REQ-018 On the header handshake (m_hdr_valid & m_hdr_ready), SHALL enter PAYLOAD.
REQ-019 In PAYLOAD: m_tdata, m_tvalid and m_tlast SHALL equal requester grant's signals, and s_tready[grant] = m_tready.
REQ-020 On m_tvalid & m_tready & m_tlast, SHALL enter IDLE and set rr_ptr = (grant+1) mod PORT_COUNT, wrapping from PORT_COUNT-1 to 0.
REQ-021 Non-granted requesters SHALL see ready=0 at all times; m_hdr_valid SHALL be 0 outside HEADER and m_tvalid SHALL be 0 outside PAYLOAD.
REQ-022 SHALL ignore payload beats presented before the owner's header completes, since s_tready stays 0 until PAYLOAD.
REQ-023 SHALL complete a single-beat packet (tlast on the first beat) in one PAYLOAD cycle, then return to IDLE.
REQ-024 SHALL not allow a new request arriving during HEADER or PAYLOAD to preempt the owner; it is evaluated at the next IDLE.
REQ-025 SHALL hold state indefinitely under backpressure (m_hdr_ready or m_tready low), with no timeout.
REQ-026 SHALL take a minimum of 3 cycles per packet (IDLE, HEADER, PAYLOAD); back-to-back packets SHALL include one IDLE cycle.

Reset
REQ-027 Reset SHALL force state IDLE, rr_ptr=0, grant=0, busy=0, m_hdr_valid=0, m_tvalid=0, m_tlast=0, and all s_hdr_ready and s_tready to 0, effective on the cycle after reset is sampled high.
REQ-028 Reset asserted mid-packet SHALL abandon the packet with no completion beat; after reset deasserts, arbitration SHALL restart from rr_ptr=0.
REQ-029 m_hdr_data and m_tdata are don't-care while their valid is low.

Verification
REQ-030 Reset scenario: reset held 2 cycles with all valids high -> all readies 0, m_hdr_valid=0, m_tvalid=0, busy=0.
REQ-031 Single-requester scenario: PORT_COUNT=2, requester 1 sends header dest_port=0x1234 plus 4 beats (0xA0..0xA3) -> m_hdr_valid is high 1 cycle after request, m_hdr_data dest_port=0x1234, m beats are 0xA0..0xA3 with tlast on 0xA3, grant=1, and rr_ptr then wraps to 0.
REQ-032 Simultaneous-request scenario: both requesters request from reset -> requester 0 is served first, then requester 1 after one IDLE cycle, then requester 0 again; no beat is interleaved.
REQ-033 Backpressure scenario: m_tready toggles 1,0,0,1 during a 3-beat packet -> no beat is lost or duplicated, and s_tready[grant] mirrors m_tready.
REQ-034 Mid-packet reset scenario: reset asserted after 2 of 5 beats -> outputs return to reset values the next cycle; a fresh request from requester 1 then gets grant=1 with its new header.
REQ-035 Single-beat scenario: PORT_COUNT=4, requesters 2 and 3 request with single-beat packets and rr_ptr=3 -> requester 3 is served first, then requester 2, and rr_ptr ends at 3.
